// File: rtl/lcd_frame_fetch.sv
// rtl/lcd_frame_fetch.sv - RGB565 line prefetch into ping-pong buffer with registered RGB888 out (option: FB_SWAP_EN)
module lcd_frame_fetch #(
    parameter int H_ACTIVE    = 480,
    parameter int V_ACTIVE    = 272,
    parameter int V_LAST      = 350,
    parameter int ADDR_W      = 18,
    parameter int FRAME_WORDS = 130560
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic              frame_sel,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata,
    output logic [7:0]        Red,
    output logic [7:0]        Green,
    output logic [7:0]        Blue,
    output logic              underrun
);

    localparam logic [8:0] LAST_COL = 9'(H_ACTIVE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [9:0]        r_drawx_q;
    logic [9:0]        r_tgt;
    logic [8:0]        r_col;
    logic [ADDR_W-1:0] r_line_addr;
    logic [15:0]       r_rd_word;
    logic              r_blank_d;
    logic [15:0]       r_lbuf [0:1][0:H_ACTIVE-1];

    logic              w_line_start;
    logic              w_launch;
    logic              w_last_col;
    logic              w_wr_en;
    logic              w_set_underrun;
    logic [9:0]        w_tgt;
    logic [ADDR_W-1:0] w_base;
    logic [ADDR_W-1:0] w_line_addr_next;

    assign w_line_start     = (DrawX == 10'd0) && (r_drawx_q != 10'd0);
    assign w_tgt            = (DrawY == 10'(V_LAST)) ? 10'd0 : DrawY + 10'd1;
    assign w_launch         = w_line_start && (w_tgt < 10'(V_ACTIVE));
    assign w_last_col       = (r_col == LAST_COL);
    assign w_line_addr_next = w_base + ADDR_W'(w_tgt) * ADDR_W'(H_ACTIVE);
    assign mem_addr         = r_line_addr + ADDR_W'(r_col);

`ifdef FB_SWAP_EN
    logic r_frame_hi;
    logic w_frame_hi;

    // Sampled where the line-0 prefetch launches so that fetch already uses the new frame.
    assign w_frame_hi = (w_line_start && (DrawY == 10'(V_LAST))) ? frame_sel : r_frame_hi;
    assign w_base     = w_frame_hi ? ADDR_W'(FRAME_WORDS) : '0;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_frame_hi <= 1'b0;
        end else begin
            r_frame_hi <= w_frame_hi;
        end
    end
`else
    logic w_unused_frame_sel;

    assign w_unused_frame_sel = frame_sel;
    assign w_base             = '0;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        mem_req        = 1'b0;
        w_wr_en        = 1'b0;
        w_set_underrun = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_launch) begin
                    w_state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                mem_req = 1'b1;
                w_wr_en = mem_ack;
                // A new line arriving mid-fetch abandons the old line and starts the new one at once.
                if (w_line_start) begin
                    w_set_underrun = 1'b1;
                    w_state_next   = w_launch ? S_FETCH : S_IDLE;
                end else if (mem_ack && w_last_col) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (w_line_start) begin
                    w_state_next = w_launch ? S_FETCH : S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_drawx_q   <= 10'd0;
            r_tgt       <= 10'd0;
            r_col       <= 9'd0;
            r_line_addr <= '0;
            underrun    <= 1'b0;
        end else begin
            r_drawx_q <= DrawX;
            if (w_set_underrun) begin
                underrun <= 1'b1;
            end
            if (w_launch) begin
                r_tgt       <= w_tgt;
                r_col       <= 9'd0;
                r_line_addr <= w_line_addr_next;
            end else if (w_wr_en && !w_last_col) begin
                r_col <= r_col + 9'd1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (w_wr_en) begin
            r_lbuf[r_tgt[0]][r_col] <= mem_rdata;
        end
    end

    always_ff @(posedge Clk) begin
        if (DrawX < 10'(H_ACTIVE)) begin
            r_rd_word <= r_lbuf[DrawY[0]][DrawX[8:0]];
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_blank_d <= 1'b0;
            Red       <= 8'd0;
            Green     <= 8'd0;
            Blue      <= 8'd0;
        end else begin
            r_blank_d <= blank;
            if (r_blank_d) begin
                Red   <= {r_rd_word[15:11], r_rd_word[15:13]};
                Green <= {r_rd_word[10:5], r_rd_word[10:9]};
                Blue  <= {r_rd_word[4:0], r_rd_word[4:2]};
            end else begin
                Red   <= 8'd0;
                Green <= 8'd0;
                Blue  <= 8'd0;
            end
        end
    end

endmodule

// File: doc/lcd_frame_fetch.md
Name: lcd_frame_fetch

Overview:
- Pixel-data stage directly downstream of the 480x272 LCD timing generator. Consumes DrawX/DrawY/blank from it.
- Prefetches the next display line from the 16-bit RGB565 frame buffer into a ping-pong line buffer.
- Drives registered 8-bit-per-channel RGB to the panel, aligned to the current pixel.
- All logic runs in the 50 MHz Clk domain. Pixel period is 7 Clk, line period is 525 pixels.

Parameters:
- H_ACTIVE, 480, visible pixels per line.
- V_ACTIVE, 272, visible lines per frame.
- V_LAST, 350, last DrawY value (line counter wraps to 0 after it).
- ADDR_W, 18, frame-buffer word-address width.
- FRAME_WORDS, 130560, words per frame (H_ACTIVE*V_ACTIVE).

Ports:
- Clk  in  1  50 MHz system clock.
- Reset  in  1  asynchronous, active-high reset.
- DrawX  in  10  current pixel column from timing generator.
- DrawY  in  10  current line from timing generator.
- blank  in  1  active-low blanking; 1 = visible pixel.
- frame_sel  in  1  frame-buffer select (used only with FB_SWAP_EN).
- mem_req  out  1  read request to frame-buffer memory.
- mem_addr  out  ADDR_W  word address of the request.
- mem_ack  in  1  one-cycle acknowledge; mem_rdata is valid in the same cycle.
- mem_rdata  in  16  RGB565 word.
- Red, Green, Blue  out  8 each  pixel colour.
- underrun  out  1  sticky flag: a line fetch did not complete in time.

Behaviour:
- Reset values: mem_req=0, mem_addr=0, Red/Green/Blue=0, underrun=0, FSM=IDLE. Line-buffer contents undefined.
- Reset asserted mid-fetch drops mem_req immediately and abandons the fetch.
- Line-start detect: DrawX is registered each Clk. line_start is a one-Clk pulse when DrawX==0 and the registered DrawX!=0.
- Target line: tgt = (DrawY==V_LAST) ? 0 : DrawY+1, captured at line_start.
  - A fetch is launched only if tgt < V_ACTIVE. Otherwise the FSM stays IDLE.
  - Line 0 is prefetched during line V_LAST.
- Line buffer: 2 banks x H_ACTIVE x 16 bits. Bank index = line[0].
  - Fetch writes bank tgt[0]; display reads bank DrawY[0].
  - The only collision (tgt=0 while DrawY=350) occurs during blanking and is harmless.
- FSM states:
  - IDLE -> FETCH on line_start with valid tgt. Set col=0 and line_addr = base + tgt*H_ACTIVE.
  - FETCH: mem_req=1, mem_addr=line_addr+col. Both are held stable until mem_ack.
    - On mem_ack: write mem_rdata to bank[tgt[0]][col].
    - If col==H_ACTIVE-1, go to DONE; else col+1, with a new request presented the next cycle.
    - At most one request is outstanding.
  - DONE -> IDLE on the next line_start, which re-evaluates launch in the same cycle.
- Underrun: line_start while in FETCH sets underrun and restarts the fetch for the new tgt in the same cycle. mem_req stays asserted with the new address. underrun is cleared only by Reset.
- Base address: 0 when FB_SWAP_EN is undefined.
- Pixel pipeline, 2 Clk latency from a DrawX/DrawY change:
  - Stage 1: synchronous line-buffer read at (DrawY[0], DrawX) when DrawX < H_ACTIVE. blank is delayed 1 Clk.
  - Stage 2: RGB565 expansion R={r5,r5[4:2]}, G={g6,g6[5:4]}, B={b5,b5[4:2]}, output registered.
  - Outputs are forced to 0 when delayed blank==0.
- Budget: 480 words within 3675 Clk per line, so the memory must average an ack within 7 Clk per request.

Optional Feature:
- Macro FB_SWAP_EN.
- Defined: frame_sel is sampled at the line_start where DrawY==V_LAST, giving base = frame_sel ? FRAME_WORDS : 0.
  - base is held for the whole frame, including the line-0 prefetch.
  - frame_sel changes at any other time have no effect until the next sample.
- Undefined: frame_sel is ignored and base=0.

Test Plan:
- Reset during FETCH with mem_req=1 -> mem_req=0 and RGB=0 immediately. After release the FSM is IDLE until the next line_start.
- DrawY=5, DrawX 524->0, memory acks every 2 Clk -> 480 requests at addresses 2880..3359. DONE is reached before the next line_start. underrun=0.
- DrawY=350 line_start -> fetch of line 0 at addresses 0..479. DrawY=271 line_start -> no request (tgt=272).
- Line buffer holds 0xF800 at col 10 of line 6. DrawY=6, DrawX=10, blank=1 -> Red=0xFF, Green=0, Blue=0 two Clk later. With blank=0 -> RGB=0.
- Memory never acks -> underrun=1 at the next line_start. mem_addr jumps to the new line base and underrun stays 1.
- FB_SWAP_EN defined, frame_sel=1 at DrawY=350 line_start -> line-0 fetch starts at address 130560. frame_sel toggled mid-frame -> addresses unaffected.
